// File: rtl/stdin_uart_pkg.sv
// Shared types and constants for the stdin UART receiver and its byte FIFO.
package stdin_uart_pkg;

  // Receiver FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  // 8N1 framing: eight data bits per frame, and the line idles high.
  localparam int   DATA_BITS  = 8;
  localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/stdin_uart_rx_if.sv
// Byte handshake between the receiver FIFO and the processor's stdin read.
// slave  = receiver side (drives head byte and valid)
// master = processor side (drives the pop request)
interface stdin_uart_rx_if
  import stdin_uart_pkg::*;
();
  logic                 stdin_ren;
  logic [DATA_BITS-1:0] stdin_rval;
  logic                 stdin_valid;

  modport master (output stdin_ren, input stdin_rval, input stdin_valid);
  modport slave  (input stdin_ren, output stdin_rval, output stdin_valid);
endinterface

// File: rtl/stdin_fifo.sv
// Small synchronous byte FIFO. Pointers carry one extra wrap bit so that
// full and empty can be told apart without a separate occupancy counter.
// The head byte is read combinationally and forced to zero when empty.
module stdin_fifo
  import stdin_uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 pop,
  output logic                 full,
  output logic                 empty,
  output logic [DATA_BITS-1:0] head
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DEPTH_LOG2:0]  wr_ptr_reg;
  logic [DEPTH_LOG2:0]  rd_ptr_reg;
  logic [DATA_BITS-1:0] mem [DEPTH];
  logic                 pop_ok;
  logic                 push_ok;

  assign empty = (wr_ptr_reg == rd_ptr_reg);
  assign full  = (wr_ptr_reg[DEPTH_LOG2] != rd_ptr_reg[DEPTH_LOG2]) &&
                 (wr_ptr_reg[DEPTH_LOG2-1:0] == rd_ptr_reg[DEPTH_LOG2-1:0]);

  // A pop on an empty FIFO is ignored; a push into a full FIFO is only
  // accepted when a pop in the same cycle frees the slot being written.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  assign head = empty ? '0 : mem[rd_ptr_reg[DEPTH_LOG2-1:0]];

  // Storage write; contents need no reset because empty gates the head.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg[DEPTH_LOG2-1:0]] <= din;
    end
  end

  // Pointer advance on accepted push/pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/stdin_uart_rx.sv
// 8N1 serial receiver feeding the processor's stdin read port.
// rx is synchronised, frames are sampled mid-bit and good bytes are queued
// in a small FIFO; overflow and frame_err are single-cycle status pulses.
module stdin_uart_rx
  import stdin_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int DEPTH_LOG2   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx,
  stdin_uart_rx_if.slave        sif,
  output logic                  rx_busy,
  output logic                  overflow,
  output logic                  frame_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_TERM = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_TERM = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

  rx_state_t            state_reg;
  logic                 rx_meta_reg;
  logic                 rx_s_reg;
  logic [1:0]           sync_fill_reg;
  logic                 armed_reg;
  logic [CNT_W-1:0]     sample_cnt_reg;
  logic [2:0]           bit_cnt_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 overflow_reg;
  logic                 frame_err_reg;

  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic                 stop_sample;
  logic                 push_req;

  assign fifo_pop    = sif.stdin_ren & ~fifo_empty;
  assign stop_sample = (state_reg == STOP) && (sample_cnt_reg == FULL_TERM);
  assign push_req    = stop_sample && (rx_s_reg == IDLE_LEVEL);

  // Synchroniser and arming. Both flops come out of reset preset high, so
  // the first two rx_s values are not from the line; arming waits until the
  // pipe holds real samples and the line is seen idle. A frame that was in
  // flight across reset therefore cannot be mistaken for a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_reg   <= IDLE_LEVEL;
      rx_s_reg      <= IDLE_LEVEL;
      sync_fill_reg <= 2'b00;
      armed_reg     <= 1'b0;
    end else begin
      rx_meta_reg   <= rx;
      rx_s_reg      <= rx_meta_reg;
      sync_fill_reg <= {sync_fill_reg[0], 1'b1};
      if (sync_fill_reg[1] && (rx_s_reg == IDLE_LEVEL)) begin
        armed_reg <= 1'b1;
      end
    end
  end

  // Receiver FSM: start detect, half-bit start check, mid-bit data sampling
  // and stop-bit decision, with registered status pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      sample_cnt_reg <= '0;
      bit_cnt_reg    <= '0;
      shift_reg      <= '0;
      overflow_reg   <= 1'b0;
      frame_err_reg  <= 1'b0;
    end else begin
      overflow_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if ((rx_s_reg != IDLE_LEVEL) && armed_reg) begin
            state_reg      <= START;
            sample_cnt_reg <= '0;
          end
        end
        START: begin
          if (sample_cnt_reg == HALF_TERM) begin
            if (rx_s_reg == IDLE_LEVEL) begin
              // Line went back high before mid-start: treat as a glitch.
              state_reg <= IDLE;
            end else begin
              state_reg      <= DATA;
              sample_cnt_reg <= '0;
              bit_cnt_reg    <= '0;
            end
          end else begin
            sample_cnt_reg <= sample_cnt_reg + CNT_W'(1);
          end
        end
        DATA: begin
          if (sample_cnt_reg == FULL_TERM) begin
            sample_cnt_reg <= '0;
            // LSB first: after eight shifts the first bit sits in bit 0.
            shift_reg <= {rx_s_reg, shift_reg[DATA_BITS-1:1]};
            if (bit_cnt_reg == LAST_BIT) begin
              state_reg   <= STOP;
              bit_cnt_reg <= '0;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
            end
          end else begin
            sample_cnt_reg <= sample_cnt_reg + CNT_W'(1);
          end
        end
        STOP: begin
          if (sample_cnt_reg == FULL_TERM) begin
            // Leave at mid-stop-bit so a following start edge is not missed.
            sample_cnt_reg <= '0;
            state_reg      <= IDLE;
            if (rx_s_reg == IDLE_LEVEL) begin
              if (fifo_full && !fifo_pop) overflow_reg <= 1'b1;
            end else begin
              frame_err_reg <= 1'b1;
            end
          end else begin
            sample_cnt_reg <= sample_cnt_reg + CNT_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign rx_busy   = (state_reg != IDLE);
  assign overflow  = overflow_reg;
  assign frame_err = frame_err_reg;

  stdin_fifo #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_req),
    .din   (shift_reg),
    .pop   (sif.stdin_ren),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (sif.stdin_rval)
  );

  assign sif.stdin_valid = ~fifo_empty;

endmodule
